// File: rtl/branch_redirect_ctrl.sv
// branch_redirect_ctrl: captures a taken branch/jump resolved in EX and turns it into
// a one-cycle PC redirect plus IF/ID and ID/EX flushes, holding through memory stalls.
module branch_redirect_ctrl #(
    parameter int PC_W = 9
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            ex_valid,
    input  logic            Branch,
    input  logic            PcSel,
    input  logic [31:0]     BrPC,
    input  logic            stall,
    input  logic            clr_cnt,
    output logic            pc_redirect,
    output logic [PC_W-1:0] redirect_pc,
    output logic            flush_ifid,
    output logic            flush_idex,
    output logic            busy,
    output logic            target_err,
    output logic [15:0]     br_count,
    output logic [15:0]     taken_count
);
    typedef enum logic [1:0] {IDLE, PEND, FLUSH} state_t;

    state_t           r_state, w_next;
    logic [PC_W-1:0]  r_redirect_pc;
    logic             r_redirect, r_busy, r_err;
    logic [15:0]      r_br_cnt, r_tk_cnt;
    logic             w_accept, w_take, w_bad;

    assign w_accept = (r_state == IDLE) && ex_valid && Branch;
    assign w_take   = w_accept && PcSel;
    assign w_bad    = (BrPC[1:0] != 2'b00) || ((BrPC >> PC_W) != 32'd0);

    always_ff @(posedge clk) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_take) w_next = stall ? PEND : FLUSH;
            PEND:    if (!stall) w_next = FLUSH;
            FLUSH:   if (!stall) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with r_state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_redirect_pc <= '0;
            r_redirect    <= 1'b0;
            r_busy        <= 1'b0;
            r_err         <= 1'b0;
            r_br_cnt      <= '0;
            r_tk_cnt      <= '0;
        end else begin
            r_redirect <= (w_next == FLUSH);
            r_busy     <= (w_next != IDLE);
            if (w_take) r_redirect_pc <= BrPC[PC_W-1:0];
            if (w_take && w_bad) r_err <= 1'b1;
            if (clr_cnt) begin
                r_br_cnt <= '0;
                r_tk_cnt <= '0;
            end else begin
                if (w_accept && r_br_cnt != 16'hFFFF) r_br_cnt <= r_br_cnt + 16'd1;
                if (w_take && r_tk_cnt != 16'hFFFF)   r_tk_cnt <= r_tk_cnt + 16'd1;
            end
        end
    end

    assign pc_redirect = r_redirect;
    assign flush_ifid  = r_redirect;
    assign flush_idex  = r_redirect;
    assign redirect_pc = r_redirect_pc;
    assign busy        = r_busy;
    assign target_err  = r_err;
    assign br_count    = r_br_cnt;
    assign taken_count = r_tk_cnt;
endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// tb_branch_redirect_ctrl: directed vectors with hand-computed expectations.
module tb_branch_redirect_ctrl;
    logic        clk = 1'b0;
    logic        reset, ex_valid, Branch, PcSel, stall, clr_cnt;
    logic [31:0] BrPC;
    logic        pc_redirect, flush_ifid, flush_idex, busy, target_err;
    logic [8:0]  redirect_pc;
    logic [15:0] br_count, taken_count;
    int          n_tests = 0, n_fail = 0;

    branch_redirect_ctrl #(.PC_W(9)) dut (
        .clk(clk), .reset(reset), .ex_valid(ex_valid), .Branch(Branch), .PcSel(PcSel),
        .BrPC(BrPC), .stall(stall), .clr_cnt(clr_cnt), .pc_redirect(pc_redirect),
        .redirect_pc(redirect_pc), .flush_ifid(flush_ifid), .flush_idex(flush_idex),
        .busy(busy), .target_err(target_err), .br_count(br_count), .taken_count(taken_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic b, input logic p, input logic [31:0] pc);
        ex_valid = v;
        Branch   = b;
        PcSel    = p;
        BrPC     = pc;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_redir"}, {31'd0, pc_redirect}, 32'd0);
        check({tag, "_fifid"}, {31'd0, flush_ifid}, 32'd0);
        check({tag, "_fidex"}, {31'd0, flush_idex}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        reset = 1'b0; stall = 1'b0; clr_cnt = 1'b0;
        drive(1, 1, 1, 32'h0000_0203);
        tick(); tick();
        check_idle("rst");
        check("rst_pc", {23'd0, redirect_pc}, 32'd0);
        check("rst_err", {31'd0, target_err}, 32'd0);
        check("rst_br", {16'd0, br_count}, 32'd0);
        check("rst_tk", {16'd0, taken_count}, 32'd0);
        drive(0, 0, 0, 32'd0);
        reset = 1'b1;
        tick();

        drive(1, 1, 1, 32'h0000_0040);
        tick();
        check("tk_redir", {31'd0, pc_redirect}, 32'd1);
        check("tk_fifid", {31'd0, flush_ifid}, 32'd1);
        check("tk_fidex", {31'd0, flush_idex}, 32'd1);
        check("tk_busy", {31'd0, busy}, 32'd1);
        check("tk_pc", {23'd0, redirect_pc}, 32'h40);
        check("tk_br", {16'd0, br_count}, 32'd1);
        check("tk_tk", {16'd0, taken_count}, 32'd1);
        drive(1, 1, 1, 32'h0000_0080);
        tick();
        check_idle("b2b");
        check("b2b_pc", {23'd0, redirect_pc}, 32'h40);
        check("b2b_br", {16'd0, br_count}, 32'd1);
        check("b2b_tk", {16'd0, taken_count}, 32'd1);

        drive(1, 1, 0, 32'h0000_0100);
        tick();
        check_idle("nt");
        check("nt_br", {16'd0, br_count}, 32'd2);
        check("nt_tk", {16'd0, taken_count}, 32'd1);
        check("nt_pc", {23'd0, redirect_pc}, 32'h40);

        stall = 1'b1;
        drive(1, 1, 1, 32'h0000_0100);
        tick();
        check("st0_busy", {31'd0, busy}, 32'd1);
        check("st0_redir", {31'd0, pc_redirect}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("st_busy", {31'd0, busy}, 32'd1);
            check("st_redir", {31'd0, pc_redirect}, 32'd0);
        end
        stall = 1'b0;
        tick();
        check("st_flush", {31'd0, pc_redirect}, 32'd1);
        check("st_pc", {23'd0, redirect_pc}, 32'h100);
        stall = 1'b1;
        tick();
        check("st_hold", {31'd0, pc_redirect}, 32'd1);
        stall = 1'b0;
        tick();
        check_idle("st_done");
        check("st_br", {16'd0, br_count}, 32'd3);
        check("st_tk", {16'd0, taken_count}, 32'd2);
        check("st_err", {31'd0, target_err}, 32'd0);
        drive(0, 0, 0, 32'd0);
        tick();

        drive(1, 1, 1, 32'h0000_0202);
        tick();
        check("err_pc", {23'd0, redirect_pc}, 32'h002);
        check("err_set", {31'd0, target_err}, 32'd1);
        drive(0, 0, 0, 32'd0);
        tick(); tick();
        check("err_sticky", {31'd0, target_err}, 32'd1);
        check("err_br", {16'd0, br_count}, 32'd4);
        check("err_tk", {16'd0, taken_count}, 32'd3);

        drive(1, 1, 0, 32'h0000_0400);
        tick();
        check("hi_err", {31'd0, target_err}, 32'd1);
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        check("clr_br", {16'd0, br_count}, 32'd0);
        check("clr_tk", {16'd0, taken_count}, 32'd0);

        for (int i = 0; i < 65535; i++) tick();
        check("sat_reach", {16'd0, br_count}, 32'hFFFF);
        tick();
        check("sat_hold", {16'd0, br_count}, 32'hFFFF);
        check("sat_tk", {16'd0, taken_count}, 32'd0);

        drive(1, 1, 1, 32'h0000_0040);
        tick();
        check("rf_redir", {31'd0, pc_redirect}, 32'd1);
        reset = 1'b0;
        tick();
        check_idle("rf");
        check("rf_pc", {23'd0, redirect_pc}, 32'd0);
        check("rf_err", {31'd0, target_err}, 32'd0);
        check("rf_br", {16'd0, br_count}, 32'd0);
        check("rf_tk", {16'd0, taken_count}, 32'd0);
        drive(0, 0, 0, 32'd0);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_idle("post_rst");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/branch_redirect_ctrl.md
BRANCH_REDIRECT_CTRL -- requirements
Module: branch_redirect_ctrl

Interface
REQ-001 Parameter PC_W, default 9: PC width; redirect_pc width.
REQ-002 clk  input  1  rising-edge clock; the only clock.
REQ-003 reset  input  1  synchronous, active-low reset (0 = reset), sampled on clk rising edge.
REQ-004 ex_valid  input  1  EX stage holds a valid (non-bubble) instruction.
REQ-005 Branch  input  1  EX instruction is a branch or jump.
REQ-006 PcSel  input  1  branch unit resolved taken branch or jump in EX.
REQ-007 BrPC  input  32  resolved target from branch unit, valid when PcSel=1.
REQ-008 stall  input  1  pipeline freeze (memory busy); no stage advances while 1.
REQ-009 clr_cnt  input  1  synchronous clear of both counters.
REQ-010 pc_redirect  output  1  PC register loads redirect_pc this cycle.
REQ-011 redirect_pc  output  PC_W  redirect target.
REQ-012 flush_ifid  output  1  squash IF/ID register contents.
REQ-013 flush_idex  output  1  squash ID/EX register contents.
REQ-014 busy  output  1  redirect captured but not yet consumed.
REQ-015 target_err  output  1  sticky: a taken target was misaligned or out of range.
REQ-016 br_count  output  16  accepted branch instructions, saturating.
REQ-017 taken_count  output  16  accepted taken branches, saturating.

Function
REQ-018 FSM states SHALL be IDLE, PEND, FLUSH; all outputs registered.
REQ-019 Accept event SHALL be: state IDLE and ex_valid=1 and Branch=1; taken accept additionally requires PcSel=1; accept is allowed regardless of stall.
REQ-020 On taken accept, the block SHALL latch BrPC[PC_W-1:0] into redirect_pc.
REQ-021 On taken accept, next state SHALL be FLUSH if stall=0, PEND if stall=1.
REQ-022 PEND: hold latched target; stay while stall=1; go to FLUSH on first cycle with stall=0.
REQ-023 In FLUSH, pc_redirect, flush_ifid and flush_idex SHALL be 1; outputs hold while stall=1; when stall=0 the redirect is consumed and next state SHALL be IDLE.
REQ-024 Latency: with stall=0 throughout, pc_redirect SHALL assert exactly one cycle after the accept cycle and last exactly one cycle.
REQ-025 In PEND and FLUSH, ex_valid, Branch and PcSel SHALL be ignored (the EX instruction is wrong-path); no accept, no counting.
REQ-026 In IDLE, pc_redirect, flush_ifid and flush_idex SHALL be 0; not-taken branches cause no state change.
REQ-027 busy SHALL be 1 exactly in PEND and FLUSH.
REQ-028 target_err SHALL set on taken accept when BrPC[1:0]!=0 or BrPC[31:PC_W]!=0; redirect still proceeds with the truncated target; cleared only by reset.
REQ-029 br_count SHALL increment by 1 on each accept; taken_count on each taken accept; each saturates at 16'hFFFF.
REQ-030 clr_cnt=1 SHALL zero both counters that cycle, taking priority over a simultaneous increment; FSM unaffected.
REQ-031 Accept while stall=1 SHALL be counted once, not per stalled cycle (subsequent cycles are in PEND).

Reset
REQ-032 reset=0 at a clock edge SHALL force state IDLE, redirect_pc=0, pc_redirect=0, flush_ifid=0, flush_idex=0, busy=0, target_err=0, br_count=0, taken_count=0.
REQ-033 Reset during PEND or FLUSH SHALL discard the pending redirect; no pc_redirect after reset release.
REQ-034 Inputs SHALL be ignored while reset=0.

Verification
REQ-035 Taken, no stall: ex_valid=Branch=PcSel=1, BrPC=0x0000_0040 for one cycle -> next cycle pc_redirect=flush_ifid=flush_idex=1, redirect_pc=0x040, for one cycle; br_count=1, taken_count=1.
REQ-036 Taken with stall: accept with stall=1, stall held 3 more cycles -> busy=1, pc_redirect=0 for 4 cycles, then pc_redirect=1 for one cycle after stall falls; counters +1 only.
REQ-037 Back-to-back: taken accept then ex_valid=Branch=PcSel=1, BrPC=0x80 in the FLUSH cycle -> second ignored, redirect_pc stays 0x040, taken_count=1.
REQ-038 Not-taken: Branch=1, PcSel=0 -> no redirect, br_count+1, taken_count unchanged.
REQ-039 Error: taken with BrPC=0x0000_0202 -> target_err=1 sticky, redirect_pc=0x002 (9-bit truncation).
REQ-040 Saturation and reset: preload br_count to 0xFFFF, accept -> stays 0xFFFF; reset=0 in FLUSH -> all outputs 0, no later redirect.
